// File: rtl/rv_muldiv_pkg.sv
// rv_muldiv_pkg: shared encodings for the RV32M multiply/divide sequencer.
package rv_muldiv_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide, one bit per cycle, shared accumulator.
module muldiv_seq
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]     ma, mb;
  logic [XLEN:0]       sum;
  logic [XLEN+1:0]     r, diff;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rmd;
  assign sa       = funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM} && rs1[XLEN-1];
  assign sb       = funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM} && rs2[XLEN-1];
  assign ma       = sa ? -rs1 : rs1;
  assign mb       = sb ? -rs2 : rs2;
  assign div_zero = funct3[2] && rs2 == '0;
  assign div_ovf  = funct3[2] && !funct3[0] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1;
  // multiply: add multiplicand into the high half when the current multiplier bit is set, then shift right
  assign sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  // divide: shift the next dividend bit into the remainder and trial-subtract the divisor
  assign r    = {rem_q, acc_q[XLEN-1]};
  assign diff = r - {2'b0, opb_q};
  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rmd  = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: if (start) begin
        f3_d    = funct3;
        neg_d   = funct3 == F3_REM ? sa : sa ^ sb;
        opb_d   = funct3[2] ? mb : ma;
        acc_d   = {{XLEN{1'b0}}, funct3[2] ? ma : mb};
        rem_d   = '0;
        cnt_d   = CNT_W'(XLEN);
        state_d = (div_zero || div_ovf) ? S_DONE : S_CALC;
        if (div_zero) res_d = funct3[1] ? rs1 : '1;
        else if (div_ovf) res_d = funct3[1] ? '0 : rs1;
      end
      S_CALC: begin
        acc_d   = f3_q[2] ? {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~diff[XLEN+1]}
                          : {sum, acc_q[XLEN-1:1]};
        rem_d   = f3_q[2] ? (diff[XLEN+1] ? r[XLEN:0] : diff[XLEN:0]) : rem_q;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = cnt_q == CNT_W'(1) ? S_FIX : S_CALC;
      end
      S_FIX: begin
        res_d   = f3_q[2] ? (f3_q[1] ? rmd : quo)
                          : (f3_q == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      opb_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
    end
  end
  assign busy   = state_q != S_IDLE;
  assign stall  = busy || (start && state_q == S_IDLE && !flush);
  assign done   = state_q == S_DONE;
  assign result = res_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors, expected results queued at issue and checked by a done monitor.
module tb_muldiv_seq;
  import rv_muldiv_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        busy, stall, done;
  logic [31:0] result;
  typedef struct {
    logic [31:0] res;
    int          t0;
    int          lat;
    string       name;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int   cyc = 0, n_chk = 0, n_bad = 0;
  logic hold;
  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .busy(busy), .stall(stall), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk({e.name, "_res"}, result, e.res);
        chk({e.name, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end
  task automatic pulse(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f;
    rs1    = a;
    rs2    = b;
    start  = 1'b1;
    #1 chk("stall_on_start", {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic launch(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat);
    @(negedge clk);
    q.push_back('{res, cyc + 1, lat, name});
    pulse(f, a, b);
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 80) begin
      @(negedge clk);
      #2 n++;
    end
    chk("drain_pending", q.size(), 32'd0);
    q.delete();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;
    launch("mul_7xm3", F3_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    hold = 1'b1;
    for (int i = 0; i < 34; i++) begin
      #1 if (!(busy && stall)) hold = 1'b0;
      @(negedge clk);
    end
    chk("mul_busy_hold", {31'd0, hold}, 32'd1);
    drain();
    launch("mulh", F3_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 34); drain();
    launch("mulhu", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34); drain();
    launch("mulhsu", F3_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34); drain();
    launch("div_m7_2", F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34); drain();
    launch("rem_m7_2", F3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34); drain();
    launch("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 34); drain();
    launch("divu_by0", F3_DIVU, 32'h1234, 32'd0, 32'hFFFFFFFF, 1); drain();
    launch("rem_by0", F3_REM, 32'h1234, 32'd0, 32'h1234, 1); drain();
    launch("div_ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1); drain();
    launch("rem_ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1); drain();
    launch("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2, 34); drain();
    pulse(F3_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_result", result, 32'd2);
    repeat (40) @(negedge clk);
    launch("mul_3x4", F3_MUL, 32'd3, 32'd4, 32'd12, 34); drain();
    launch("divu_ign", F3_DIVU, 32'd100, 32'd7, 32'd14, 34);
    repeat (3) @(negedge clk);
    pulse(F3_MUL, 32'd5, 32'd5);
    drain();
    launch("mul_rst", F3_MUL, 32'd9, 32'd9, 32'd81, 34);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_stall", {31'd0, stall}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_result", result, 32'd0);
    rst = 1'b0;
    launch("mul_6x7", F3_MUL, 32'd6, 32'd7, 32'd42, 34); drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
